// File: rtl/gray_seq_checker.sv
// Receive-side checker for an N-bit Gray sequence: converts to binary, checks successor legality,
// tracks lock, counts errors. Define GRAY_CHK_BIDIR_EN to also accept -1 steps (dir=1).
`timescale 1ns/1ps
module gray_seq_checker #(
  parameter int unsigned N        = 3,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOSS_THR = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [N-1:0]     gray_in,
  input  logic             clr_err,
  output logic [N-1:0]     bin_out,
  output logic             bin_valid,
  output logic             step_err,
  output logic             wrap,
  output logic             seq_done,
  output logic             locked,
  output logic             dir,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned CW = $clog2(LOSS_THR + 1);
  localparam logic [N-1:0]  MAXV     = '1;
  localparam logic [N:0]    RUN_FULL = {1'b1, {N{1'b0}}};
  localparam logic [CW-1:0] LOSS     = CW'(LOSS_THR);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t        state;
  logic [N-1:0]  bin;
  logic [N-1:0]  prev;
  logic [N-1:0]  prev_inc;
  logic [N:0]    run_cnt;
  logic [N:0]    run_inc;
  logic [CW-1:0] consec_err;
  logic [CW-1:0] consec_inc;
  logic          legal_up;
  logic          legal_dn;
  logic          wrap_hit;

  // Each binary bit is the XOR of the Gray bits at and above it.
  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < N; i++)
      bin[i] = ^(gray_in >> i);
  end

  assign prev_inc   = prev + 1'b1;
  assign run_inc    = run_cnt + 1'b1;
  assign consec_inc = consec_err + 1'b1;
  assign legal_up   = (bin == prev_inc);

`ifdef GRAY_CHK_BIDIR_EN
  logic [N-1:0] prev_dec;
  assign prev_dec = prev - 1'b1;
  assign legal_dn = (bin == prev_dec);
`else
  assign legal_dn = 1'b0;
`endif

  assign wrap_hit = (legal_up && prev == MAXV && bin == '0) ||
                    (legal_dn && prev == '0 && bin == MAXV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= UNLOCKED;
      prev       <= '0;
      run_cnt    <= '0;
      consec_err <= '0;
      bin_out    <= '0;
      bin_valid  <= 1'b0;
      step_err   <= 1'b0;
      wrap       <= 1'b0;
      seq_done   <= 1'b0;
      locked     <= 1'b0;
      dir        <= 1'b0;
      err_count  <= '0;
    end else begin
      bin_valid <= 1'b0;
      step_err  <= 1'b0;
      wrap      <= 1'b0;
      seq_done  <= 1'b0;
      if (in_valid) begin
        bin_out   <= bin;
        bin_valid <= 1'b1;
        prev      <= bin;
        case (state)
          UNLOCKED: begin
            state      <= LOCKED;
            locked     <= 1'b1;
            run_cnt    <= {{N{1'b0}}, 1'b1};
            consec_err <= '0;
          end
          LOCKED: begin
            if (legal_up || legal_dn) begin
              consec_err <= '0;
              dir        <= legal_dn;
              wrap       <= wrap_hit;
              if (run_inc == RUN_FULL) begin
                seq_done <= 1'b1;
                run_cnt  <= '0;
              end else begin
                run_cnt  <= run_inc;
              end
            end else begin
              step_err <= 1'b1;
              run_cnt  <= {{N{1'b0}}, 1'b1};
              if (err_count != '1)
                err_count <= err_count + 1'b1;
              if (consec_inc == LOSS) begin
                state      <= UNLOCKED;
                locked     <= 1'b0;
                consec_err <= '0;
              end else begin
                consec_err <= consec_inc;
              end
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
      // Placed last so a clear overrides a same-cycle increment.
      if (clr_err)
        err_count <= '0;
    end
  end

endmodule

// File: tb/tb_gray_seq_checker.sv
// Scoreboard bench for gray_seq_checker (N=3, CNT_W=8, LOSS_THR=4); follows GRAY_CHK_BIDIR_EN.
`timescale 1ns/1ps
module tb_gray_seq_checker;

  localparam int N = 3;
  localparam int CNT_W = 8;
  localparam int LOSS_THR = 4;
  localparam int M = 1 << N;
  localparam int MAXE = (1 << CNT_W) - 1;
`ifdef GRAY_CHK_BIDIR_EN
  localparam bit BIDIR = 1'b1;
`else
  localparam bit BIDIR = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0]     bin;
    logic             bv;
    logic             se;
    logic             wr;
    logic             sd;
    logic             lk;
    logic             dr;
    logic [CNT_W-1:0] ec;
  } obs_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [N-1:0]     gray_in = '0;
  logic             clr_err = 1'b0;
  logic [N-1:0]     bin_out;
  logic             bin_valid, step_err, wrap, seq_done, locked, dir;
  logic [CNT_W-1:0] err_count;

  int n_tests = 0;
  int n_fail = 0;
  obs_t exp_q[$];

  // Reference model state
  bit         m_locked;
  int         m_prev, m_run, m_consec, m_err, m_bin;
  bit         m_dir;

  gray_seq_checker #(.N(N), .CNT_W(CNT_W), .LOSS_THR(LOSS_THR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .gray_in(gray_in), .clr_err(clr_err),
    .bin_out(bin_out), .bin_valid(bin_valid), .step_err(step_err), .wrap(wrap),
    .seq_done(seq_done), .locked(locked), .dir(dir), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  function automatic obs_t cur_obs();
    return {bin_out, bin_valid, step_err, wrap, seq_done, locked, dir, err_count};
  endfunction

  function automatic logic [N-1:0] to_gray(input int b);
    logic [N-1:0] v;
    v = N'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    m_locked = 0; m_prev = 0; m_run = 0; m_consec = 0; m_err = 0; m_bin = 0; m_dir = 0;
    exp_q.delete();
  endtask

  // Drive one cycle, push the model's expectation, then wait until it is observable.
  task automatic step(input bit v, input logic [N-1:0] g, input bit c);
    obs_t e;
    logic [N-1:0] b;
    bit up, dn;
    e = '0;
    in_valid = v; gray_in = g; clr_err = c;
    if (v) begin
      b[N-1] = g[N-1];
      for (int k = N - 2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
      m_bin = int'(b);
      e.bv = 1'b1;
      if (!m_locked) begin
        m_locked = 1; m_prev = m_bin; m_run = 1; m_consec = 0;
      end else begin
        up = (m_bin == (m_prev + 1) % M);
        dn = BIDIR && (m_bin == (m_prev + M - 1) % M);
        if (up || dn) begin
          e.wr = (up && m_prev == M - 1 && m_bin == 0) || (dn && m_prev == 0 && m_bin == M - 1);
          m_dir = dn;
          m_run++;
          if (m_run == M) begin e.sd = 1'b1; m_run = 0; end
          m_consec = 0;
        end else begin
          e.se = 1'b1;
          if (m_err < MAXE) m_err++;
          m_run = 1;
          m_consec++;
          if (m_consec == LOSS_THR) begin m_locked = 0; m_consec = 0; end
        end
        m_prev = m_bin;
      end
    end
    if (c) m_err = 0;
    e.bin = N'(m_bin); e.lk = m_locked; e.dr = m_dir; e.ec = CNT_W'(m_err);
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; clr_err = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0; clr_err = 1'b0; gray_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    obs_t o;
    apply_reset();
    o = cur_obs();
    n_tests++;
    if (o !== obs_t'('0)) begin n_fail++; $display("FAIL reset_state got %h want 0", o); end
  endtask

  task automatic test_sequence();
    obs_t o, e;
    apply_reset();
    for (int i = 0; i < M; i++) begin
      step(1'b1, to_gray(i), 1'b0);
      e = exp_q.pop_front(); o = cur_obs();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL seq_word%0d got %h want %h", i, o, e); end
    end
    n_tests++;
    if (seq_done !== 1'b1 || bin_out !== 3'd7) begin
      n_fail++; $display("FAIL seq_done_at7 got done=%b bin=%0d want done=1 bin=7", seq_done, bin_out);
    end
    step(1'b0, '0, 1'b0);
    e = exp_q.pop_front(); o = cur_obs();
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL idle_hold got %h want %h", o, e); end
  endtask

  task automatic test_wrap();
    obs_t o, e;
    for (int i = 0; i < M; i++) begin
      step(1'b1, to_gray(i), 1'b0);
      e = exp_q.pop_front(); o = cur_obs();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL wrap_word%0d got %h want %h", i, o, e); end
      if (i == 0) begin
        n_tests++;
        if (wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_pulse got %b want 1", wrap); end
      end
    end
  endtask

  task automatic test_step_error();
    obs_t o, e;
    logic [N-1:0] pat [3];
    pat[0] = 3'b001; pat[1] = 3'b010; pat[2] = 3'b110;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, pat[i], 1'b0);
      e = exp_q.pop_front(); o = cur_obs();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL steperr_word%0d got %h want %h", i, o, e); end
      if (i == 1) begin
        n_tests++;
        if (step_err !== 1'b1 || err_count !== 8'd1) begin
          n_fail++; $display("FAIL steperr_1to3 got se=%b ec=%0d want se=1 ec=1", step_err, err_count);
        end
      end
    end
  endtask

  task automatic test_lock_loss();
    obs_t o, e;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, (i % 2) ? 3'b010 : 3'b000, 1'b0);
      e = exp_q.pop_front(); o = cur_obs();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL lockloss_word%0d got %h want %h", i, o, e); end
    end
    n_tests++;
    if (locked !== 1'b0 || err_count !== 8'd4) begin
      n_fail++; $display("FAIL lockloss_final got lk=%b ec=%0d want lk=0 ec=4", locked, err_count);
    end
  endtask

  task automatic test_saturate_clear();
    obs_t o, e;
    int bad;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'b1, (i % 2) ? 3'b010 : 3'b000, 1'b0);
      e = exp_q.pop_front(); o = cur_obs();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL sat_word%0d got %h want %h", i, o, e); end
    end
    n_tests++;
    if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_count got %0d want 255", err_count); end
    if (!m_locked) begin
      step(1'b1, 3'b000, 1'b0);
      e = exp_q.pop_front(); o = cur_obs();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL sat_relock got %h want %h", o, e); end
    end
    bad = (m_prev + 2) % M;
    step(1'b1, to_gray(bad), 1'b1);
    e = exp_q.pop_front(); o = cur_obs();
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL clr_vs_err got %h want %h", o, e); end
    n_tests++;
    if (err_count !== 8'd0 || step_err !== 1'b1) begin
      n_fail++; $display("FAIL clr_wins got ec=%0d se=%b want ec=0 se=1", err_count, step_err);
    end
  endtask

  task automatic test_down_step();
    obs_t o, e;
    logic [N-1:0] pat [4];
    pat[0] = 3'b010; pat[1] = 3'b011; pat[2] = 3'b000; pat[3] = 3'b100;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pat[i], 1'b0);
      e = exp_q.pop_front(); o = cur_obs();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL down_word%0d got %h want %h", i, o, e); end
      if (i == 1) begin
        n_tests++;
        if (step_err !== !BIDIR || dir !== BIDIR) begin
          n_fail++; $display("FAIL down_3to2 got se=%b dir=%b want se=%b dir=%b", step_err, dir, !BIDIR, BIDIR);
        end
      end
      if (i == 3) begin
        n_tests++;
        if (wrap !== BIDIR) begin n_fail++; $display("FAIL down_wrap got %b want %b", wrap, BIDIR); end
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t o, e;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, to_gray(i), 1'b0);
      e = exp_q.pop_front(); o = cur_obs();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL prerst_word%0d got %h want %h", i, o, e); end
    end
    #2 rst_n = 1'b0;
    #1;
    o = cur_obs();
    n_tests++;
    if (o !== obs_t'('0)) begin n_fail++; $display("FAIL async_reset got %h want 0", o); end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 3'b101, 1'b0);
    e = exp_q.pop_front(); o = cur_obs();
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL relock got %h want %h", o, e); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_wrap();
    test_step_error();
    test_lock_loss();
    test_saturate_clear();
    test_down_step();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
